// File: rtl/dac_buf_if.sv
// dac_buf_if: MCU byte-write port and DAC word-read port of the sample buffer.
// master drives addresses/data, slave (the buffer) returns the read word.
interface dac_buf_if #(
    parameter int WADDR_W = 11,
    parameter int RADDR_W = 9,
    parameter int RD_W    = 32
);
    logic               wren;
    logic [WADDR_W-1:0] wraddress;
    logic [7:0]         data;
    logic [RADDR_W-1:0] rdaddress;
    logic [RD_W-1:0]    q;

    modport master (
        output wren,
        output wraddress,
        output data,
        output rdaddress,
        input  q
    );

    modport slave (
        input  wren,
        input  wraddress,
        input  data,
        input  rdaddress,
        output q
    );
endinterface

// File: rtl/dac_buf.sv
// dac_buf: 2 KiB dual-port ring buffer, byte writes from the MCU side,
// 32-bit stereo-sample reads (little-endian lanes) for the DAC engine.
module dac_buf #(
    parameter int WADDR_W = 11,
    parameter int RADDR_W = 9,
    parameter int RD_W    = 32
) (
    input  logic     clock,
    input  logic     reset_n,
    dac_buf_if.slave bus
);
    localparam int DEPTH = 1 << RADDR_W;
    localparam int LANES = RD_W / 8;

    logic [LANES-1:0][7:0] q_w;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0] ram [DEPTH];
        logic [7:0] q_l;
        logic       we;

        assign we = reset_n && bus.wren
                 && (bus.wraddress[1:0] == 2'(g));

        // Lane write port; left without reset so it maps onto block RAM.
        always_ff @(posedge clock) begin
            if (we) begin
                ram[bus.wraddress[WADDR_W-1:2]] <= bus.data;
            end
        end

        // Lane read register; same-edge write is not seen (old data).
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                q_l <= '0;
            end else begin
                q_l <= ram[bus.rdaddress];
            end
        end

        assign q_w[g] = q_l;
    end

    assign bus.q = q_w;
endmodule

// File: tb/tb_dac_buf.sv
// tb_dac_buf: directed stimulus feeding an expected-value queue;
// a monitor pops one entry per clock and compares q after each edge.
module tb_dac_buf;
    typedef struct {
        bit          chk;
        logic [31:0] exp;
        string       tag;
    } item_t;

    logic  clock;
    logic  reset_n;
    item_t sb [$];
    int    checks = 0;
    int    errors = 0;
    bit    done   = 0;

    dac_buf_if bus ();

    dac_buf dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [7:0] pat(input int a);
        return 8'((a ^ (a >> 3)) & 8'hFF);
    endfunction

    // One clock of stimulus: drive at negedge, queue what q must be after the edge.
    task automatic cyc(input bit we, input int wa, input logic [7:0] d,
                       input int ra, input bit chk, input logic [31:0] exp,
                       input string tag);
        item_t it;
        @(negedge clock);
        bus.wren      = we;
        bus.wraddress = 11'(wa);
        bus.data      = d;
        bus.rdaddress = 9'(ra);
        it.chk = chk;
        it.exp = exp;
        it.tag = tag;
        sb.push_back(it);
        @(posedge clock);
    endtask

    task automatic wr(input int wa, input logic [7:0] d);
        cyc(1'b1, wa, d, 0, 1'b0, 32'h0, "wr");
    endtask

    task automatic rd(input int ra, input logic [31:0] exp, input string tag);
        cyc(1'b0, 0, 8'h00, ra, 1'b1, exp, tag);
    endtask

    // Monitor: compare the registered read word just after each rising edge.
    initial begin
        item_t it;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                if (it.chk) begin
                    checks++;
                    if (bus.q !== it.exp) begin
                        errors++;
                        $display("FAIL %s: q=%h expected %h",
                                 it.tag, bus.q, it.exp);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        int          waitc;
        reset_n       = 1'b0;
        bus.wren      = 1'b0;
        bus.wraddress = '0;
        bus.data      = '0;
        bus.rdaddress = '0;

        rd(0, 32'h0, "reset_q0");
        rd(1, 32'h0, "reset_q1");
        @(negedge clock);
        reset_n = 1'b1;

        wr(11'h000, 8'h11);
        wr(11'h001, 8'h22);
        wr(11'h002, 8'h33);
        wr(11'h003, 8'h44);
        rd(0, 32'h44332211, "lane_pack");

        wr(11'h002, 8'hAA);
        rd(0, 32'h44AA2211, "partial_wr");

        wr(11'h7FC, 8'h80);
        wr(11'h7FD, 8'h00);
        wr(11'h7FE, 8'hFF);
        wr(11'h7FF, 8'h7F);
        rd(9'h1FF, 32'h7FFF0080, "top_word");
        rd(0, 32'h44AA2211, "top_w0_kept");

        wr(11'h014, 8'h00);
        wr(11'h015, 8'h00);
        wr(11'h016, 8'h00);
        wr(11'h017, 8'h00);
        cyc(1'b1, 11'h014, 8'h5A, 5, 1'b1, 32'h0, "rdw_old");
        rd(5, 32'h0000005A, "rdw_new");

        rd(0, 32'h44AA2211, "pre_reset");
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.q !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: q=%h expected %h", bus.q, 32'h0);
        end
        cyc(1'b1, 11'h000, 8'hEE, 0, 1'b1, 32'h0, "reset_hold");
        cyc(1'b1, 11'h7FF, 8'hEE, 0, 1'b1, 32'h0, "reset_hold2");
        #2;
        reset_n = 1'b1;
        rd(0, 32'h44AA2211, "post_reset_w0");
        rd(9'h1FF, 32'h7FFF0080, "post_reset_top");

        for (int a = 0; a < 2048; a++) begin
            wr(a, pat(a));
        end
        for (int n = 0; n < 512; n++) begin
            w = {pat(4*n+3), pat(4*n+2), pat(4*n+1), pat(4*n)};
            rd(n, w, "sweep");
        end
        rd(0, {pat(3), pat(2), pat(1), pat(0)}, "sweep_wrap");

        waitc = 0;
        while (sb.size() > 0 && waitc < 20) begin
            @(posedge clock);
            waitc++;
        end
        #2;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
